// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_N = 32;
  localparam int CNT_W = $clog2(DIV_N);

  typedef struct packed {
    logic dbz;
    logic ovf;
  } exc_t;

  // Operands arrive zero-extended so one helper serves any N up to 64.
  function automatic exc_t calc_exc(input logic [63:0] hi, input logic [63:0] dv);
    exc_t e;
    e.dbz = (dv == 64'd0);
    e.ovf = (dv != 64'd0) && (hi >= dv);
    return e;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N+1:0] sh;

  assign sh     = {r, q_msb};
  assign q_bit  = (sh >= (N+2)'(divisor));
  assign r_next = q_bit ? (N+1)'(sh - (N+2)'(divisor)) : sh[N:0];

endmodule

// File: rtl/seq_divider_64by32.sv
// Iterative 2N/N unsigned restoring divider with valid/ready on both sides.
// Build option SEQ_DIVIDER_FAST_EXCEPT_EN: divide-by-zero and overflow skip the iterations.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   CALC  | one quotient bit per clock; fin marks the final result-load cycle
//   DONE  | out_valid high, results held until out_ready
module seq_divider_64by32
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N);

  state_t       state;
  logic [CW-1:0] cnt;
  logic         fin;
  logic [N:0]   r;
  logic [N-1:0] q;
  logic [N-1:0] lo;
  logic [N-1:0] dv;
  exc_t         exc_q;
  exc_t         exc_in;
  logic [N:0]   r_nx;
  logic         q_bit;

  assign exc_in = calc_exc(64'(dividend[2*N-1:N]), 64'(divisor));

  div_restore_step #(.N(N)) u_step (
    .r       (r),
    .q_msb   (q[N-1]),
    .divisor (dv),
    .r_next  (r_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      fin         <= 1'b0;
      r           <= '0;
      q           <= '0;
      lo          <= '0;
      dv          <= '0;
      exc_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r        <= {1'b0, dividend[2*N-1:N]};
            q        <= dividend[N-1:0];
            lo       <= dividend[N-1:0];
            dv       <= divisor;
            exc_q    <= exc_in;
            in_ready <= 1'b0;
            state    <= CALC;
`ifdef SEQ_DIVIDER_FAST_EXCEPT_EN
            if (exc_in.dbz || exc_in.ovf) begin
              cnt <= '0;
              fin <= 1'b1;
            end else begin
              cnt <= CW'(N-1);
              fin <= 1'b0;
            end
`else
            cnt <= CW'(N-1);
            fin <= 1'b0;
`endif
          end
        end
        CALC: begin
          if (fin) begin
            fin         <= 1'b0;
            state       <= DONE;
            out_valid   <= 1'b1;
            div_by_zero <= exc_q.dbz;
            overflow    <= exc_q.ovf;
            if (exc_q.dbz || exc_q.ovf) begin
              quotient  <= '1;
              remainder <= lo;
            end else begin
              quotient  <= q;
              remainder <= r[N-1:0];
            end
          end else begin
            r <= r_nx;
            q <= {q[N-2:0], q_bit};
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_64by32.sv
// Scoreboard bench for seq_divider_64by32 (expects the same SEQ_DIVIDER_FAST_EXCEPT_EN setting as the RTL).
module tb_seq_divider_64by32;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   dividend;
  logic [31:0]   divisor;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   quotient;
  logic [31:0]   remainder;
  logic          div_by_zero;
  logic          overflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_divider_64by32 #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [63:0] dd, input logic [31:0] dv);
    exp_t        e;
    logic [31:0] hi;
    hi    = dd[63:32];
    e.dbz = (dv == 32'd0);
    e.ovf = (dv != 32'd0) && (hi >= dv);
    e.lat = N + 1;
    if (e.dbz || e.ovf) begin
      e.q = 32'hFFFF_FFFF;
      e.r = dd[31:0];
`ifdef SEQ_DIVIDER_FAST_EXCEPT_EN
      e.lat = 1;
`endif
    end else begin
      e.q = 32'(dd / {32'd0, dv});
      e.r = 32'(dd % {32'd0, dv});
    end
    return e;
  endfunction

  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [63:0] dd, input logic [31:0] dv);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_issue", in_ready, 1'b1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    sb.push_back(model(dd, dv));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input bit stall, input string tag);
    int   lat = 0;
    exp_t e;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    e = sb.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 64'd12345;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        check({tag, "_stall_valid"}, out_valid, 1'b1);
        check({tag, "_stall_in_ready"}, in_ready, 1'b0);
        check({tag, "_stall_quot"}, quotient, e.q);
        check({tag, "_stall_rem"}, remainder, e.r);
      end
      in_valid = 1'b0;
    end
    check({tag, "_quot"}, quotient, e.q);
    check({tag, "_rem"}, remainder, e.r);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    check({tag, "_ovf"}, overflow, e.ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] hi;
    logic        seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_flags", {div_by_zero, overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    dd = 64'h1234_5678 * 64'h1000_0001;
    issue(dd, 32'h1000_0001);
    check("roundtrip_model_q", sb[0].q, 32'h1234_5678);
    check("roundtrip_model_r", sb[0].r, 32'd0);
    collect(1'b0, "roundtrip");

    issue(64'd100, 32'd7);
    check("basic_model_q", sb[0].q, 32'd14);
    collect(1'b0, "basic");
    issue(64'h0000_0000_FFFF_FFFF, 32'd1);
    collect(1'b0, "max");
    issue(64'h5, 32'd0);
    check("dbz_model_r", sb[0].r, 32'd5);
    collect(1'b0, "div0");
    issue(64'h0000_0002_0000_0000, 32'd2);
    check("ovf_model_flag", sb[0].ovf, 1'b1);
    collect(1'b0, "ovf");

    out_ready = 1'b0;
    issue(64'd987654321, 32'd1234);
    collect(1'b1, "stall");
    issue(64'h0000_00AB_CDEF_0123, 32'h0000_1000);
    collect(1'b0, "b2b_a");
    issue(64'h0000_0000_DEAD_BEEF, 32'h0000_0010);
    collect(1'b0, "b2b_b");

    issue(64'h0000_0001_2345_6789, 32'h0ABC_DEF1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_quot", quotient, 32'd0);
    check("midrst_rem", remainder, 32'd0);
    check("midrst_flags", {div_by_zero, overflow}, 2'b00);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    check("midrst_no_out_valid", seen, 1'b0);
    issue(64'd1000, 32'd10);
    collect(1'b0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          dv = $urandom;
          dd = {$urandom, $urandom};
        end
        1: begin
          dv = $urandom | 32'd1;
          hi = $urandom % dv;
          dd = {hi, 32'($urandom)};
        end
        2: begin
          dv = 32'd1;
          hi = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
          dd = {hi, 32'($urandom)};
        end
        3: begin
          dv = 32'hFFFF_FFFF;
          hi = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
          dd = {hi, 32'($urandom)};
        end
        4: begin
          dv = $urandom | 32'd1;
          hi = dv - 32'd1;
          dd = {hi, 32'($urandom)};
        end
        default: begin
          dv = 32'd0;
          dd = {$urandom, $urandom};
        end
      endcase
      issue(dd, dv);
      collect(1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
